mem_arbiter_2x1: RTL and testbench

Two-master arbiter that shares one single-port 16x4096 RAM (read latency fixed, one request accepted per cycle) between the MU0 CPU (master 0) and a second requester such as a program loader or debug port (master 1). It grants the RAM each cycle by round-robin, drives the RAM port combinationally from the winner, and routes returning read data back to the issuing master. It sits between `CPU_MU0`-style cores and `RAM_16x4096` instances in the top-level and in benches.

---
 rtl/mem_arbiter_2x1_pkg.sv | 18 +
 rtl/mem_arbiter_2x1_if.sv | 26 ++
 rtl/mem_arbiter_2x1_rd_pipe.sv | 29 ++
 rtl/mem_arbiter_2x1.sv | 94 +++++++++
 tb/tb_mem_arbiter_2x1.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_2x1_pkg.sv
// Shared types for the two-master RAM arbiter: default bus widths, master id and
// the read-return tag that rides the latency pipe.
package mem_arb_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  typedef logic master_id_t;

  localparam master_id_t M0 = 1'b0;
  localparam master_id_t M1 = 1'b1;

  typedef struct packed {
    logic       valid;
    master_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/mem_arbiter_2x1_if.sv
// Per-master request/response bus. The master modport is the requester side; the
// slave modport is what the arbiter presents to each requester.
interface mem_arbiter_2x1_if #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DATA_W
);

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/mem_arbiter_2x1_rd_pipe.sv
// Fixed-depth shift register of read tags. The tag leaving the last stage lines up
// with the RAM's read data for the read that pushed it.
module mem_arb_rd_pipe
  import mem_arb_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t push,
  output rd_tag_t pop
);

  rd_tag_t stage [READ_LATENCY];

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: every stage is cleared, not just the head; a stale valid left in the
      // pipe would report a read that was discarded by reset.
      for (int i = 0; i < READ_LATENCY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= push;
      for (int i = 1; i < READ_LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  assign pop = stage[READ_LATENCY-1];

endmodule

// File: rtl/mem_arbiter_2x1.sv
// Round-robin arbiter sharing one fixed-latency single-port RAM between two masters.
// The grant is combinational; returning read data is steered by a tag pipe.
module mem_arbiter_2x1 #(
  parameter int ADDR_W       = mem_arb_pkg::ADDR_W,
  parameter int DATA_W       = mem_arb_pkg::DATA_W,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_2x1_if.slave  m0,
  mem_arbiter_2x1_if.slave  m1,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);

  import mem_arb_pkg::*;

  logic              req0;
  logic              req1;
  logic              contend;
  logic              accept;
  master_id_t        last_grant;
  master_id_t        winner;
  logic [ADDR_W-1:0] sel_address;
  logic [DATA_W-1:0] sel_writedata;
  logic              sel_read;
  logic              sel_write;
  rd_tag_t           push_tag;
  rd_tag_t           pop_tag;

  assign req0    = m0.read | m0.write;
  assign req1    = m1.read | m1.write;
  assign contend = req0 & req1;
  assign accept  = rst & (req0 | req1);

  // On contention the master that did not win last time goes first.
  always_comb begin
    // NOTE: defaults come first so every path assigns each output and no latch is
    // inferred.
    winner = M0;
    if (contend)   winner = ~last_grant;
    else if (req1) winner = M1;
  end

  // Idle cycles fall through to master 0's address and write data.
  always_comb begin
    sel_address   = m0.address;
    sel_writedata = m0.writedata;
    sel_read      = m0.read;
    sel_write     = m0.write;
    if (winner == M1) begin
      sel_address   = m1.address;
      sel_writedata = m1.writedata;
      sel_read      = m1.read;
      sel_write     = m1.write;
    end
  end

  assign mem_address   = sel_address;
  assign mem_writedata = sel_writedata;
  assign mem_write     = accept & sel_write;
  assign mem_read      = accept & sel_read & ~sel_write;

  assign m0.waitrequest = ~rst | (contend & (winner != M0));
  assign m1.waitrequest = ~rst | (contend & (winner != M1));

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so this register updates from pre-edge values,
    // independent of process ordering.
    if (!rst)        last_grant <= M1;
    else if (accept) last_grant <= winner;
  end

  assign push_tag = '{valid: mem_read, id: winner};

  mem_arb_rd_pipe #(
    .READ_LATENCY (READ_LATENCY)
  ) u_rd_pipe (
    .clk  (clk),
    .rst  (rst),
    .push (push_tag),
    .pop  (pop_tag)
  );

  // Data goes to both masters; only the valid pulse is steered by the tag.
  assign m0.readdata      = mem_readdata;
  assign m1.readdata      = mem_readdata;
  assign m0.readdatavalid = rst & pop_tag.valid & (pop_tag.id == M0);
  assign m1.readdatavalid = rst & pop_tag.valid & (pop_tag.id == M1);

endmodule

// File: tb/tb_mem_arbiter_2x1.sv
// Bench for mem_arbiter_2x1: two instances (read latency 1 and 3) driven with the same
// directed stimulus, checked every cycle against a transaction-level model.
module tb_mem_arbiter_2x1;

  localparam int AW   = 12;
  localparam int DW   = 16;
  localparam int NDUT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [1:0][AW-1:0]  in_addr;
  logic [1:0]          in_rd;
  logic [1:0]          in_wr;
  logic [1:0][DW-1:0]  in_wd;

  logic [1:0][1:0]          o_wait;
  logic [1:0][1:0]          o_rdv;
  logic [1:0][1:0][DW-1:0]  o_rdata;
  logic [1:0][AW-1:0]       o_maddr;
  logic [1:0]               o_mrd;
  logic [1:0]               o_mwr;
  logic [1:0][DW-1:0]       o_mwd;

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [DW-1:0] init_word(input int a);
    if (a == 5) return 16'h1234;
    return DW'(a * 7) ^ 16'hA500;
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;

    mem_arbiter_2x1_if #(.ADDR_W(AW), .DATA_W(DW)) m0 ();
    mem_arbiter_2x1_if #(.ADDR_W(AW), .DATA_W(DW)) m1 ();

    logic [AW-1:0] mem_address;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_writedata;
    logic [DW-1:0] mem_readdata;

    logic [DW-1:0] ram     [4096];
    bit            written [4096];
    logic [DW-1:0] dpipe   [L];

    mem_arbiter_2x1 #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(L)) dut (
      .clk           (clk),
      .rst           (rst),
      .m0            (m0),
      .m1            (m1),
      .mem_address   (mem_address),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_writedata (mem_writedata),
      .mem_readdata  (mem_readdata)
    );

    assign m0.address   = in_addr[0];
    assign m0.read      = in_rd[0];
    assign m0.write     = in_wr[0];
    assign m0.writedata = in_wd[0];
    assign m1.address   = in_addr[1];
    assign m1.read      = in_rd[1];
    assign m1.write     = in_wr[1];
    assign m1.writedata = in_wd[1];

    assign o_wait[g]  = {m1.waitrequest, m0.waitrequest};
    assign o_rdv[g]   = {m1.readdatavalid, m0.readdatavalid};
    assign o_rdata[g] = {m1.readdata, m0.readdata};
    assign o_maddr[g] = mem_address;
    assign o_mrd[g]   = mem_read;
    assign o_mwr[g]   = mem_write;
    assign o_mwd[g]   = mem_writedata;

    // RAM with L cycles of read latency; unwritten words read their initial pattern.
    always @(posedge clk) begin
      if (mem_write) begin
        ram[mem_address]     <= mem_writedata;
        written[mem_address] <= 1'b1;
      end
      dpipe[0] <= written[mem_address] ? ram[mem_address] : init_word(int'(mem_address));
      for (int i = 1; i < L; i++) dpipe[i] <= dpipe[i-1];
    end
    assign mem_readdata = dpipe[L-1];
  end

  // Model: expected returns as {instance, due edge, master, data} records.
  typedef struct {
    int            d;
    int            due;
    int            id;
    logic [DW-1:0] data;
  } ret_t;

  ret_t          rq [$];
  logic [DW-1:0] ref_mem [4096];
  bit            ref_wr  [4096];
  int            edge_cnt = 0;
  int            last_m   = 1;
  int            acc_w    = 0;
  bit            acc_any  = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [1:0][1:0]         s_wait;
  logic [1:0][1:0]         s_rdv;
  logic [1:0][1:0][DW-1:0] s_rdata;
  logic [1:0][AW-1:0]      s_maddr;
  logic [1:0]              s_mrd;
  logic [1:0]              s_mwr;
  int                      rv_cnt [2][2];
  logic [1:0][1:0][7:0]    hist;

  function automatic logic [DW-1:0] ref_rd(input int a);
    return ref_wr[a] ? ref_mem[a] : init_word(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    bit            r0, r1, expw, exprdv;
    int            w;
    logic [DW-1:0] expdata;
    r0 = in_rd[0] | in_wr[0];
    r1 = in_rd[1] | in_wr[1];
    if (r0 && r1) w = 1 - last_m;
    else if (r1)  w = 1;
    else          w = 0;
    acc_w   = w;
    acc_any = rst && (r0 || r1);
    for (int d = 0; d < NDUT; d++) begin
      for (int n = 0; n < 2; n++) begin
        expw = !rst || (r0 && r1 && (w != n));
        check($sformatf("d%0d_m%0d_waitrequest", d, n), 32'(o_wait[d][n]), 32'(expw));
        exprdv  = 1'b0;
        expdata = '0;
        if (rst) begin
          foreach (rq[i]) begin
            if (rq[i].d == d && rq[i].due == edge_cnt && rq[i].id == n) begin
              exprdv  = 1'b1;
              expdata = rq[i].data;
            end
          end
        end
        check($sformatf("d%0d_m%0d_readdatavalid", d, n), 32'(o_rdv[d][n]), 32'(exprdv));
        if (exprdv)
          check($sformatf("d%0d_m%0d_readdata", d, n), 32'(o_rdata[d][n]), 32'(expdata));
      end
      check($sformatf("d%0d_mem_read", d), 32'(o_mrd[d]), 32'(acc_any && in_rd[w] && !in_wr[w]));
      check($sformatf("d%0d_mem_write", d), 32'(o_mwr[d]), 32'(acc_any && in_wr[w]));
      if (rst) begin
        check($sformatf("d%0d_mem_address", d), 32'(o_maddr[d]), 32'(in_addr[w]));
        check($sformatf("d%0d_mem_writedata", d), 32'(o_mwd[d]), 32'(in_wd[w]));
      end
    end
  endtask

  task automatic update();
    ret_t keep [$];
    if (!rst) begin
      rq.delete();
      last_m = 1;
    end else begin
      foreach (rq[i]) if (rq[i].due > edge_cnt) keep.push_back(rq[i]);
      rq = keep;
    end
    edge_cnt++;
    if (acc_any) begin
      last_m = acc_w;
      if (in_wr[acc_w]) begin
        ref_mem[in_addr[acc_w]] = in_wd[acc_w];
        ref_wr[in_addr[acc_w]]  = 1'b1;
      end else if (in_rd[acc_w]) begin
        for (int d = 0; d < NDUT; d++)
          rq.push_back('{d: d, due: edge_cnt + lat(d) - 1, id: acc_w,
                         data: ref_rd(int'(in_addr[acc_w]))});
      end
    end
  endtask

  // One clock cycle: check at the falling edge, advance the model at the rising edge.
  task automatic step();
    @(negedge clk);
    compare();
    s_wait  = o_wait;
    s_rdv   = o_rdv;
    s_rdata = o_rdata;
    s_maddr = o_maddr;
    s_mrd   = o_mrd;
    s_mwr   = o_mwr;
    for (int d = 0; d < NDUT; d++)
      for (int n = 0; n < 2; n++)
        if (o_rdv[d][n]) rv_cnt[d][n]++;
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic clear_counts();
    for (int d = 0; d < NDUT; d++)
      for (int n = 0; n < 2; n++) rv_cnt[d][n] = 0;
  endtask

  initial begin
    rst        = 1'b0;
    in_rd      = 2'b11;
    in_wr      = 2'b00;
    in_addr[0] = 12'h001;
    in_addr[1] = 12'h002;
    in_wd      = '0;
    clear_counts();

    // Reset held with both masters requesting.
    repeat (3) step();
    check("lit_reset_wait", 32'(s_wait), 32'hF);
    check("lit_reset_strobes", 32'({s_mrd, s_mwr}), 32'h0);
    check("lit_reset_rdv", 32'(s_rdv), 32'h0);

    // Single master, back-to-back reads; return overlaps the next accept.
    rst        = 1'b1;
    in_rd      = 2'b01;
    in_addr[0] = 12'h005;
    clear_counts();
    step();
    check("lit_single_accept", 32'({s_wait[0][0], s_mrd[0]}), 32'b01);
    check("lit_single_addr", 32'(s_maddr[0]), 32'h005);
    in_addr[0] = 12'h006;
    step();
    check("lit_single_rdv_l1", 32'({s_rdv[0][0], s_rdv[0][1]}), 32'b10);
    check("lit_single_data_l1", 32'(s_rdata[0][0]), 32'h1234);
    in_addr[0] = 12'h007;
    step();
    in_rd = 2'b00;
    repeat (4) step();
    check("lit_single_cnt_l1", 32'(rv_cnt[0][0]), 32'd3);
    check("lit_single_cnt_l3", 32'(rv_cnt[1][0]), 32'd3);
    check("lit_single_m1_silent", 32'(rv_cnt[0][1] + rv_cnt[1][1]), 32'd0);

    // Contention from reset: grants alternate starting with m0.
    rst   = 1'b0;
    in_rd = 2'b11;
    step();
    rst        = 1'b1;
    in_addr[0] = 12'h010;
    in_addr[1] = 12'h020;
    clear_counts();
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("lit_grant_%0d", i), 32'({s_wait[0][1], s_wait[0][0]}),
            (i % 2 == 0) ? 32'b10 : 32'b01);
      if (acc_any) in_addr[acc_w] = in_addr[acc_w] + 12'd1;
    end
    in_rd = 2'b00;
    repeat (4) step();
    for (int d = 0; d < NDUT; d++)
      for (int n = 0; n < 2; n++)
        check($sformatf("lit_contend_cnt_d%0d_m%0d", d, n), 32'(rv_cnt[d][n]), 32'd4);

    // Write/read mix: m1 writes 0x7FF while m0 waits, then m0 reads it back.
    in_rd      = 2'b01;
    in_addr[0] = 12'h030;
    step();
    in_addr[0] = 12'h7FF;
    in_addr[1] = 12'h7FF;
    in_wr      = 2'b10;
    in_wd[1]   = 16'hBEEF;
    step();
    check("lit_mix_m1_wins", 32'({s_wait[0][1], s_wait[0][0], s_mwr[0]}), 32'b011);
    in_wr = 2'b00;
    step();
    check("lit_mix_m0_read", 32'({s_wait[0][0], s_mrd[0]}), 32'b01);
    in_rd = 2'b00;
    step();
    check("lit_mix_rdv_l1", 32'(s_rdv[0][0]), 32'd1);
    check("lit_mix_data_l1", 32'(s_rdata[0][0]), 32'hBEEF);
    step();
    step();
    check("lit_mix_rdv_l3", 32'(s_rdv[1][0]), 32'd1);
    check("lit_mix_data_l3", 32'(s_rdata[1][0]), 32'hBEEF);

    // Read and write strobes together: write only, no return.
    in_rd      = 2'b01;
    in_wr      = 2'b01;
    in_addr[0] = 12'h100;
    in_wd[0]   = 16'h0F0F;
    step();
    check("lit_rw_both", 32'({s_mwr[0], s_mrd[0]}), 32'b10);
    in_wr = 2'b00;
    step();
    in_rd = 2'b00;
    clear_counts();
    repeat (4) step();
    check("lit_rw_one_return", 32'(rv_cnt[0][0] + rv_cnt[1][0]), 32'd2);

    // Alternating single reads: return pulses land exactly L cycles after acceptance.
    hist = '0;
    for (int i = 0; i < 8; i++) begin
      in_rd      = (i < 4) ? ((i % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      in_addr[0] = 12'(12'h040 + i);
      in_addr[1] = 12'(12'h041 + i);
      step();
      for (int d = 0; d < NDUT; d++)
        for (int n = 0; n < 2; n++) hist[d][n][i] = s_rdv[d][n];
    end
    check("lit_sweep_l1_m0", 32'(hist[0][0]), 32'b0000_1010);
    check("lit_sweep_l1_m1", 32'(hist[0][1]), 32'b0001_0100);
    check("lit_sweep_l3_m0", 32'(hist[1][0]), 32'b0010_1000);
    check("lit_sweep_l3_m1", 32'(hist[1][1]), 32'b0101_0000);

    // Reset one cycle after a read accept: the read is never reported.
    in_rd      = 2'b01;
    in_addr[0] = 12'h050;
    step();
    in_rd = 2'b00;
    rst   = 1'b0;
    step();
    check("lit_midreset_rdv", 32'(s_rdv), 32'h0);
    rst = 1'b1;
    clear_counts();
    repeat (4) step();
    check("lit_midreset_none_l1", 32'(rv_cnt[0][0] + rv_cnt[0][1]), 32'd0);
    check("lit_midreset_none_l3", 32'(rv_cnt[1][0] + rv_cnt[1][1]), 32'd0);
    in_rd      = 2'b11;
    in_addr[0] = 12'h060;
    in_addr[1] = 12'h061;
    step();
    check("lit_post_reset_grant", 32'({s_wait[0][1], s_wait[0][0]}), 32'b10);
    in_rd = 2'b00;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
